// File: rtl/zxw_io_responder_v_pkg.sv
// Shared I/O address map for the responder and the CPU's data-bus decode.
package zxw_io_responder_v_pkg;

    localparam logic [7:0] IO_DHR  = 8'hFF;
    localparam logic [7:0] IO_DLR  = 8'hFE;
    localparam logic [7:0] IO_SW   = 8'hFD;
    localparam logic [7:0] IO_PB   = 8'hFC;
    localparam logic [5:0] IO_BASE = 6'b111111;

    function automatic logic io_is_hit(input logic [7:0] addr);
        return addr[7:2] == IO_BASE;
    endfunction

endpackage

// File: rtl/zxw_debounce_v.sv
// Single-bit 2-flop synchroniser plus counter debouncer with one-cycle edge pulses.
module zxw_debounce_v #(
    parameter int unsigned DB_CYCLES   = 16,
    parameter int unsigned DB_W        = 16,
    parameter logic        RESET_LEVEL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pin_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    localparam logic [DB_W-1:0] CNT_LAST = DB_W'(DB_CYCLES - 1);
    localparam logic [DB_W-1:0] CNT_ONE  = DB_W'(1);
    localparam logic [DB_W-1:0] CNT_MAX  = {DB_W{1'b1}};

    logic            sync1_q, sync2_q;
    logic            level_q, level_d;
    logic [DB_W-1:0] cnt_q, cnt_d;

    // A zero count means STABLE; any nonzero count means a change is PENDING.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync2_q;
            end else if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + CNT_ONE;
            end else begin
                cnt_d = cnt_q;
            end
        end
    end

    // Pulses are combinational so the consumer can act on the same edge the level moves.
    assign rise_o  = level_d & ~level_q;
    assign fall_o  = ~level_d & level_q;
    assign level_o = level_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= RESET_LEVEL;
            sync2_q <= RESET_LEVEL;
            level_q <= RESET_LEVEL;
            cnt_q   <= '0;
        end else begin
            sync1_q <= pin_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/zxw_io_responder_v.sv
// Data-bus target for 0xFC-0xFF: display registers, debounced switches, sticky button flags.
module zxw_io_responder_v
    import zxw_io_responder_v_pkg::*;
#(
    parameter int unsigned DB_CYCLES     = 16,
    parameter int unsigned DB_W          = 16,
    parameter bit          PB_ACTIVE_LOW = 1'b1
) (
    input  logic       Clock_pin,
    input  logic       Resetn_pin,
    input  logic [7:0] io_addr,
    input  logic [3:0] io_wdata,
    input  logic       io_wr,
    input  logic       io_rd,
    output logic [3:0] io_rdata,
    output logic       io_hit,
    input  logic [3:0] SW_pin,
    input  logic [3:0] PB_pin,
    output logic [3:0] DHR_pin,
    output logic [3:0] DLR_pin
);

    localparam logic PB_RELEASED = PB_ACTIVE_LOW ? 1'b1 : 1'b0;

    logic [3:0] sw_level, sw_rise, sw_fall;
    logic [3:0] pb_level, pb_rise, pb_fall;
    logic [3:0] pb_press;
    logic       unused_dbg;

    for (genvar i = 0; i < 4; i++) begin : g_sw
        zxw_debounce_v #(
            .DB_CYCLES  (DB_CYCLES),
            .DB_W       (DB_W),
            .RESET_LEVEL(1'b0)
        ) u_sw_db (
            .clk    (Clock_pin),
            .rst_n  (Resetn_pin),
            .pin_i  (SW_pin[i]),
            .level_o(sw_level[i]),
            .rise_o (sw_rise[i]),
            .fall_o (sw_fall[i])
        );
    end

    for (genvar i = 0; i < 4; i++) begin : g_pb
        zxw_debounce_v #(
            .DB_CYCLES  (DB_CYCLES),
            .DB_W       (DB_W),
            .RESET_LEVEL(PB_RELEASED)
        ) u_pb_db (
            .clk    (Clock_pin),
            .rst_n  (Resetn_pin),
            .pin_i  (PB_pin[i]),
            .level_o(pb_level[i]),
            .rise_o (pb_rise[i]),
            .fall_o (pb_fall[i])
        );
    end

    assign pb_press   = PB_ACTIVE_LOW ? pb_fall : pb_rise;
    assign unused_dbg = ^{sw_rise, sw_fall, pb_level};

    logic [3:0] dhr_q, dhr_d;
    logic [3:0] dlr_q, dlr_d;
    logic [3:0] flags_q, flags_d;
    logic [3:0] flag_clr;
    logic       wr_en;

    // io_wr/io_rd are single-cycle strobes qualified by io_addr; the target never
    // stalls, so a strobe is consumed at the edge it is sampled and read data is
    // valid combinationally in the same cycle.
    always_comb begin
        io_hit   = io_is_hit(io_addr);
        wr_en    = io_wr & io_hit;
        dhr_d    = dhr_q;
        dlr_d    = dlr_q;
        flag_clr = 4'h0;
        if (wr_en && io_addr == IO_DHR) dhr_d = io_wdata;
        if (wr_en && io_addr == IO_DLR) dlr_d = io_wdata;
        if (io_rd && io_addr == IO_PB) flag_clr = 4'hF;
        if (wr_en && io_addr == IO_PB) flag_clr = flag_clr | io_wdata;
        // Set after clear so a press landing on a clearing access is kept.
        flags_d = (flags_q & ~flag_clr) | pb_press;
    end

    always_comb begin
        io_rdata = 4'h0;
        case (io_addr)
            IO_DHR:  io_rdata = dhr_q;
            IO_DLR:  io_rdata = dlr_q;
            IO_SW:   io_rdata = sw_level;
            IO_PB:   io_rdata = flags_q;
            default: io_rdata = 4'h0;
        endcase
    end

    always_ff @(posedge Clock_pin or negedge Resetn_pin) begin
        if (!Resetn_pin) begin
            dhr_q   <= 4'h0;
            dlr_q   <= 4'h0;
            flags_q <= 4'h0;
        end else begin
            dhr_q   <= dhr_d;
            dlr_q   <= dlr_d;
            flags_q <= flags_d;
        end
    end

    assign DHR_pin = dhr_q;
    assign DLR_pin = dlr_q;

endmodule

// File: tb/tb_zxw_io_responder_v.sv
// Directed bench for zxw_io_responder_v with a short debounce window.
module tb_zxw_io_responder_v;

    localparam int unsigned DBC = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] io_addr = 8'h00;
    logic [3:0] io_wdata = 4'h0;
    logic       io_wr = 1'b0;
    logic       io_rd = 1'b0;
    logic [3:0] io_rdata;
    logic       io_hit;
    logic [3:0] sw = 4'h0;
    logic [3:0] pb = 4'hF;
    logic [3:0] dhr, dlr;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    zxw_io_responder_v #(
        .DB_CYCLES    (DBC),
        .DB_W         (8),
        .PB_ACTIVE_LOW(1'b1)
    ) dut (
        .Clock_pin (clk),
        .Resetn_pin(rst_n),
        .io_addr   (io_addr),
        .io_wdata  (io_wdata),
        .io_wr     (io_wr),
        .io_rd     (io_rd),
        .io_rdata  (io_rdata),
        .io_hit    (io_hit),
        .SW_pin    (sw),
        .PB_pin    (pb),
        .DHR_pin   (dhr),
        .DLR_pin   (dlr)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic peek(input logic [7:0] a, input string tag, input logic [3:0] exp);
        io_addr = a;
        #1;
        check(tag, io_rdata, exp);
    endtask

    task automatic bus_wr(input logic [7:0] a, input logic [3:0] d);
        io_addr  = a;
        io_wdata = d;
        io_wr    = 1'b1;
        tick();
        io_wr    = 1'b0;
        io_wdata = 4'h0;
    endtask

    logic [7:0] hit_addr [6];
    logic       hit_exp  [6];

    initial begin
        hit_addr = '{8'hFC, 8'hFD, 8'hFE, 8'hFF, 8'hFB, 8'h00};
        hit_exp  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

        // reset
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("rst_dhr", dhr, 4'h0);
        check("rst_dlr", dlr, 4'h0);
        peek(8'hFD, "rst_sw", 4'h0);
        peek(8'hFC, "rst_flags", 4'h0);
        tick();

        // display registers and decode
        bus_wr(8'hFF, 4'h9);
        check("dhr_wr", dhr, 4'h9);
        bus_wr(8'hFE, 4'h3);
        check("dlr_wr", dlr, 4'h3);
        peek(8'hFF, "rd_dhr", 4'h9);
        peek(8'hFE, "rd_dlr", 4'h3);
        for (int i = 0; i < 6; i++) begin
            io_addr = hit_addr[i];
            #1;
            check("io_hit", {3'b000, io_hit}, {3'b000, hit_exp[i]});
        end
        peek(8'hFB, "rd_miss", 4'h0);
        bus_wr(8'h7F, 4'h6);
        check("miss_wr_dhr", dhr, 4'h9);
        check("miss_wr_dlr", dlr, 4'h3);

        // clean switch edge: 2 sync + DBC debounce cycles
        sw = 4'b1010;
        for (int i = 0; i < 5; i++) begin
            tick();
            peek(8'hFD, "sw_lat_hold", 4'h0);
        end
        tick();
        peek(8'hFD, "sw_lat_new", 4'hA);
        bus_wr(8'hFD, 4'hF);
        peek(8'hFD, "sw_ro", 4'hA);
        check("sw_wr_dhr", dhr, 4'h9);

        // bouncing switch bit 0
        for (int i = 0; i < 10; i++) begin
            sw[0] = ~sw[0];
            tick();
            peek(8'hFD, "sw_bounce", 4'hA);
            tick();
            peek(8'hFD, "sw_bounce", 4'hA);
        end
        sw[0] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            peek(8'hFD, "sw_settle_hold", 4'hA);
        end
        tick();
        peek(8'hFD, "sw_settle_new", 4'hB);

        // press PB2 and read-to-clear
        pb = 4'b1011;
        for (int i = 0; i < 5; i++) begin
            tick();
            peek(8'hFC, "pb_lat_hold", 4'h0);
        end
        tick();
        peek(8'hFC, "pb_flag_set", 4'h4);
        io_addr = 8'hFC;
        io_rd   = 1'b1;
        #1;
        check("pb_rd_val", io_rdata, 4'h4);
        tick();
        io_rd = 1'b0;
        peek(8'hFC, "pb_rd_cleared", 4'h0);
        pb = 4'hF;
        repeat (8) tick();
        peek(8'hFC, "pb_release", 4'h0);

        // press on the same edge as a read-to-clear
        pb = 4'b1110;
        repeat (8) tick();
        peek(8'hFC, "pb0_flag", 4'h1);
        pb = 4'b1010;
        repeat (5) tick();
        io_addr = 8'hFC;
        io_rd   = 1'b1;
        #1;
        check("race_rd_old", io_rdata, 4'h1);
        tick();
        io_rd = 1'b0;
        peek(8'hFC, "race_set_wins", 4'h4);
        pb = 4'b1000;
        repeat (8) tick();
        peek(8'hFC, "pb1_flag", 4'h6);
        bus_wr(8'hFC, 4'h4);
        peek(8'hFC, "w1c", 4'h2);

        // read and write together at DHR
        io_addr  = 8'hFF;
        io_wdata = 4'h5;
        io_wr    = 1'b1;
        io_rd    = 1'b1;
        #1;
        check("rdwr_pre", io_rdata, 4'h9);
        tick();
        io_wr = 1'b0;
        io_rd = 1'b0;
        check("rdwr_dhr", dhr, 4'h5);

        // asynchronous reset mid-debounce
        bus_wr(8'hFF, 4'h9);
        check("pre_rst_dhr", dhr, 4'h9);
        sw = 4'h0;
        pb = 4'hF;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check("arst_dhr", dhr, 4'h0);
        check("arst_dlr", dlr, 4'h0);
        peek(8'hFD, "arst_sw", 4'h0);
        peek(8'hFC, "arst_flags", 4'h0);
        tick();
        rst_n = 1'b1;
        repeat (10) tick();
        peek(8'hFC, "post_rst_flags", 4'h0);
        peek(8'hFD, "post_rst_sw", 4'h0);
        check("post_rst_dhr", dhr, 4'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/zxw_io_responder_v.md
Name: zxw_io_responder_v

Overview:
- Memory-mapped I/O responder: the target side of the CPU's data-memory bus for addresses 0xFC–0xFF.
- Owns the hex-display output registers (DHR/DLR) and the switch/pushbutton input path: synchronisation, debounce and sticky press capture.
- The CPU drives address/strobes and write data. This block returns read data and an address-hit flag so the CPU can select between I/O and data RAM.

Parameters:
- DB_CYCLES, 16: consecutive stable cycles needed to accept a new debounced input level (2..65535).
- DB_W, 16: width of each debounce counter; must hold DB_CYCLES.
- PB_ACTIVE_LOW, 1: 1 = pushbutton pressed when pin is 0.

Ports:
- Clock_pin, input, 1: system clock, rising edge.
- Resetn_pin, input, 1: asynchronous active-low reset.
- io_addr, input, 8: CPU effective address.
- io_wdata, input, 4: CPU write data (accumulator A).
- io_wr, input, 1: write strobe; one cycle per store.
- io_rd, input, 1: read strobe; one cycle per load.
- io_rdata, output, 4: read data for io_addr (combinational).
- io_hit, output, 1: 1 when io_addr is in 0xFC–0xFF.
- SW_pin, input, 4: raw slide switches (asynchronous).
- PB_pin, input, 4: raw pushbuttons (asynchronous).
- DHR_pin, output, 4: high display register.
- DLR_pin, output, 4: low display register.

Behaviour:
- Reset: asynchronous on Resetn_pin=0.
  - DHR=0, DLR=0, press flags=0, debounce counters=0.
  - Sync flops = 0 for switches; released level for buttons.
  - Debounced levels: switches 0, buttons released.
  - Reset mid-debounce discards the pending change.
- Address map:
  - 0xFF: DHR, read/write.
  - 0xFE: DLR, read/write.
  - 0xFD: debounced switches, read-only; writes ignored.
  - 0xFC: pushbutton press flags, read-to-clear; write-1-to-clear.
- io_hit: pure decode of io_addr[7:2]==6'b111111, independent of strobes.
- io_rdata:
  - Combinational mux of the addressed register, pre-clear value.
  - 0 when io_hit=0.
- Writes: take effect at the rising edge where io_wr=1 and io_hit=1.
  - io_wr with io_hit=0: no effect.
- Input sync: each SW/PB bit passes through a 2-flop synchroniser. Latency pin→sync = 2 cycles.
- Debounce, per bit:
  - Counter clears whenever the sync value equals the debounced level.
  - Otherwise the counter increments.
  - When the counter reaches DB_CYCLES-1 with sync still differing, the debounced level takes the sync value and the counter clears.
  - Any bounce back to the old level before then clears the counter.
  - Total pin→debounced latency for a clean edge: 2 + DB_CYCLES cycles.
  - The counter saturates; it never wraps.
- Press detect: a debounced released→pressed transition sets flag[i] in the same cycle the debounced level changes. A release sets nothing.
- Flag clear, at the same edge:
  - io_rd=1 at 0xFC clears all flags.
  - io_wr=1 at 0xFC clears flags where io_wdata[i]=1.
- Simultaneous press and clear on the same bit: set wins, so the flag stays 1 and no press is lost.
- io_rd and io_wr together at the same address:
  - Write takes effect.
  - io_rdata shows the pre-write value.
  - Clears combine (OR).
- Multiple presses before a read collapse into one flag; no counting.
- No other state machines. Debounce is a 2-state-per-bit scheme: STABLE when count=0; PENDING while counting.

Decomposition:
- Shared package/header for the address constants IO_DHR=8'hFF, IO_DLR=8'hFE, IO_SW=8'hFD, IO_PB=8'hFC and the IO_BASE prefix 6'b111111. The CPU decode uses the same constants.
- One natural sub-module, zxw_debounce_v (parameters DB_CYCLES, DB_W, RESET_LEVEL). It contains:
  - 2-flop synchroniser;
  - per-bit counter;
  - debounced output;
  - one-cycle rise/fall pulse outputs.
- Instantiate it 8 times (4 SW, 4 PB). The top level holds the registers, decode, flags and read mux.

Test Plan (DB_CYCLES=4 for simulation):
1. Reset, then write 0x9 to 0xFF and 0x3 to 0xFE → DHR_pin=9, DLR_pin=3 after the write edge; reads of 0xFF/0xFE return 9/3; io_hit=1 for 0xFC–0xFF, 0 for 0xFB and 0x00.
2. SW_pin changes 0000→1010 cleanly → io_rdata at 0xFD stays 0000 for 5 cycles and reads 1010 from cycle 6; a write of 0xF to 0xFD leaves it 1010.
3. SW_pin[0] toggles every 2 cycles for 20 cycles, then holds 1 → debounced bit stays 0 during toggling and becomes 1 exactly 6 cycles after the last edge.
4. PB_pin[2] pressed (1→0) and held → flag reads 0100 at 0xFC; io_rd at 0xFC returns 0100 and the next read returns 0000; a release sets no flag.
5. Press debounces on the same edge as io_rd at 0xFC → read returns the old flags and flag[2] remains 1 afterwards. Write 0x4 to 0xFC → flag[2] clears; other flags are untouched.
6. Assert Resetn_pin=0 mid-debounce with DHR=9 → DHR_pin=0 immediately (asynchronous); no spurious press flag after release with buttons held released.
